// File: rtl/fifo_stream_reader.sv
// Read-side adapter that drains a fixed-latency FIFO into a valid/ready stream.
// Words in flight are tracked in a shift register and parked in a circular skid buffer.
module fifo_stream_reader #(
    parameter int WIDTH_DATA = 8,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = RD_LATENCY + 1,
    parameter int _WIDTH_CNT = $clog2(SKID_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_reg_en,
    input  logic [WIDTH_DATA-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [WIDTH_DATA-1:0] m_data,
    input  logic                  m_ready,
    output logic [_WIDTH_CNT-1:0] occ
);

    localparam int PTR_W = $clog2(SKID_DEPTH);

    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
        $error("fifo_stream_reader: RD_LATENCY must be 1 or 2");
    end
    if (SKID_DEPTH < RD_LATENCY + 1 || SKID_DEPTH > 8) begin : g_bad_depth
        $error("fifo_stream_reader: SKID_DEPTH must be in RD_LATENCY+1 .. 8");
    end

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [WIDTH_DATA-1:0] buf_q [SKID_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [_WIDTH_CNT-1:0] buf_cnt_q, buf_cnt_d, infl_cnt_s;
    logic                  capture_s, pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Popcount of the in-flight shift register.
    always_comb begin
        infl_cnt_s = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            infl_cnt_s = infl_cnt_s + _WIDTH_CNT'(inflight_q[k]);
        end
    end

    assign occ       = infl_cnt_s + buf_cnt_q;
    assign m_valid   = (buf_cnt_q != '0);
    assign m_data    = buf_q[head_q];
    assign pop_s     = m_valid && m_ready;
    assign capture_s = inflight_q[RD_LATENCY-1];
    // A same-cycle pop frees a slot, so m_ready feeds the issue decision directly.
    assign fifo_rd_en = rst_n && !fifo_empty &&
                        ((occ - _WIDTH_CNT'(pop_s)) < _WIDTH_CNT'(SKID_DEPTH));

    if (RD_LATENCY == 2) begin : g_reg_en
        assign fifo_rd_reg_en = inflight_q[0];
    end else begin : g_no_reg_en
        assign fifo_rd_reg_en = 1'b0;
    end

    // Next-state for in-flight tracking, pointers and buffer count.
    always_comb begin
        inflight_d[0] = fifo_rd_en;
        for (int k = 1; k < RD_LATENCY; k++) begin
            inflight_d[k] = inflight_q[k-1];
        end
        if (pop_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (capture_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({capture_s, pop_s})
            2'b10:   buf_cnt_d = buf_cnt_q + _WIDTH_CNT'(1);
            2'b01:   buf_cnt_d = buf_cnt_q - _WIDTH_CNT'(1);
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    // State registers; the landing word is written at tail as its in-flight bit exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            buf_cnt_q  <= '0;
            for (int k = 0; k < SKID_DEPTH; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            buf_cnt_q  <= buf_cnt_d;
            if (capture_s) begin
                buf_q[tail_q] <= fifo_rd_data;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture_s && !pop_s && buf_cnt_q == _WIDTH_CNT'(SKID_DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_s && buf_cnt_q == '0));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one instance per legal read latency,
// each fed by a small FIFO model with the matching output timing.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_ready = 1'b0;
    logic       rd_en0, reg_en0, valid0, rd_en1, reg_en1, valid1;
    logic [7:0] data0, data1, q0, q1, s1;
    logic [1:0] occ0, occ1;
    logic       empty0, empty1;
    logic [7:0] mem [0:2047];
    int         wptr = 0;
    int         rptr0, rptr1;
    int         total = 0;
    int         bad = 0;
    logic       sb_on = 1'b0;
    int         idx0, idx1;
    logic       hold0, hold1;
    logic [7:0] hd0, hd1;
    int         nc;

    typedef struct {
        logic       rdy;
        logic       e1, v1;
        logic [7:0] d1;
        int         o1;
        logic       e2, r2, v2;
        logic [7:0] d2;
        int         o2;
    } vec_t;
    vec_t tab [10];

    always #5 clk = ~clk;

    assign empty0 = (rptr0 == wptr);
    assign empty1 = (rptr1 == wptr);

    fifo_stream_reader #(.WIDTH_DATA(8), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty0), .fifo_rd_en(rd_en0),
        .fifo_rd_reg_en(reg_en0), .fifo_rd_data(q0), .m_valid(valid0),
        .m_data(data0), .m_ready(m_ready), .occ(occ0));

    fifo_stream_reader #(.WIDTH_DATA(8), .RD_LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty1), .fifo_rd_en(rd_en1),
        .fifo_rd_reg_en(reg_en1), .fifo_rd_data(q1), .m_valid(valid1),
        .m_data(data1), .m_ready(m_ready), .occ(occ1));

    // FIFO with unregistered output: word popped on an edge is valid the next cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr0 <= 0;
            q0    <= 8'h00;
        end else if (rd_en0) begin
            q0    <= mem[rptr0];
            rptr0 <= rptr0 + 1;
        end
    end

    // FIFO with registered output stage loaded by fifo_rd_reg_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr1 <= 0;
            s1    <= 8'h00;
            q1    <= 8'h00;
        end else begin
            if (rd_en1) begin
                s1    <= mem[rptr1];
                rptr1 <= rptr1 + 1;
            end
            if (reg_en1) q1 <= s1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream scoreboard: order, hold stability, occupancy bound, no read while empty.
    always @(negedge clk) begin
        #2;
        if (!sb_on) begin
            idx0 = 0; idx1 = 0; hold0 = 1'b0; hold1 = 1'b0;
        end else begin
            if (hold0) begin
                chk("hold_valid0", valid0, 1);
                chk("hold_data0", data0, hd0);
            end
            if (hold1) begin
                chk("hold_valid1", valid1, 1);
                chk("hold_data1", data1, hd1);
            end
            if (valid0 && m_ready) begin
                chk("order0", data0, mem[idx0]);
                idx0++;
            end
            if (valid1 && m_ready) begin
                chk("order1", data1, mem[idx1]);
                idx1++;
            end
            hold0 = valid0 && !m_ready; hd0 = data0;
            hold1 = valid1 && !m_ready; hd1 = data1;
            chk("occ_bound0", int'(occ0 <= 2'd2), 1);
            chk("occ_bound1", int'(occ1 <= 2'd3), 1);
            chk("rd_while_empty0", int'(rd_en0 && empty0), 0);
            chk("rd_while_empty1", int'(rd_en1 && empty1), 0);
        end
    end

    task automatic do_reset(input int npre, input logic [7:0] base);
        @(negedge clk);
        rst_n = 1'b0; sb_on = 1'b0; m_ready = 1'b0; wptr = 0;
        for (int k = 0; k < npre; k++) mem[k] = base + 8'(k);
        wptr = npre;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid0", valid0, 0);  chk("rst_valid1", valid1, 0);
        chk("rst_occ0", occ0, 0);      chk("rst_occ1", occ1, 0);
        chk("rst_rden0", rd_en0, 0);   chk("rst_rden1", rd_en1, 0);
        chk("rst_regen1", reg_en1, 0); chk("rst_data1", data1, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        //           rdy   L=1: en    v     data   occ  L=2: en  reg   v     data   occ
        tab[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        tab[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b1, 1'b1, 1'b0, 8'h00, 1};
        tab[2] = '{1'b1, 1'b1, 1'b1, 8'hA0, 2, 1'b1, 1'b1, 1'b0, 8'h00, 2};
        tab[3] = '{1'b0, 1'b0, 1'b1, 8'hA1, 2, 1'b0, 1'b1, 1'b1, 8'hA0, 3};
        tab[4] = '{1'b0, 1'b0, 1'b1, 8'hA1, 2, 1'b0, 1'b0, 1'b1, 8'hA0, 3};
        tab[5] = '{1'b1, 1'b1, 1'b1, 8'hA1, 2, 1'b1, 1'b0, 1'b1, 8'hA0, 3};
        tab[6] = '{1'b1, 1'b0, 1'b1, 8'hA2, 2, 1'b0, 1'b1, 1'b1, 8'hA1, 3};
        tab[7] = '{1'b1, 1'b0, 1'b1, 8'hA3, 1, 1'b0, 1'b0, 1'b1, 8'hA2, 2};
        tab[8] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b1, 8'hA3, 1};
        tab[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'h00, 0};

        // Idle with an empty FIFO.
        do_reset(0, 8'h00);
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("idle_rden0", rd_en0, 0); chk("idle_rden1", rd_en1, 0);
            chk("idle_valid0", valid0, 0); chk("idle_valid1", valid1, 0);
            chk("idle_occ0", occ0, 0);     chk("idle_occ1", occ1, 0);
            @(negedge clk);
        end

        // Cycle-exact latency, stall and drain vectors, starting the cycle after release.
        do_reset(4, 8'hA0);
        for (int i = 0; i < 10; i++) begin
            m_ready = tab[i].rdy;
            #1;
            chk($sformatf("v%0d_rden0", i), rd_en0, tab[i].e1);
            chk($sformatf("v%0d_regen0", i), reg_en0, 0);
            chk($sformatf("v%0d_valid0", i), valid0, tab[i].v1);
            chk($sformatf("v%0d_occ0", i), occ0, tab[i].o1);
            if (tab[i].v1) chk($sformatf("v%0d_data0", i), data0, tab[i].d1);
            chk($sformatf("v%0d_rden1", i), rd_en1, tab[i].e2);
            chk($sformatf("v%0d_regen1", i), reg_en1, tab[i].r2);
            chk($sformatf("v%0d_valid1", i), valid1, tab[i].v2);
            chk($sformatf("v%0d_occ1", i), occ1, tab[i].o2);
            if (tab[i].v2) chk($sformatf("v%0d_data1", i), data1, tab[i].d2);
            @(negedge clk);
        end

        // Back-pressure for 10 cycles, then full-rate drain of 16 words.
        do_reset(16, 8'h00);
        sb_on = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_rden0", int'(rd_en0 && occ0 == 2'd2), 0);
            chk("bp_rden1", int'(rd_en1 && occ1 == 2'd3), 0);
            @(negedge clk);
        end
        chk("bp_sat0", occ0, 2);
        chk("bp_sat1", occ1, 3);
        m_ready = 1'b1;
        for (nc = 0; nc < 200; nc++) begin
            if (idx0 >= 16 && idx1 >= 16) break;
            @(negedge clk);
        end
        chk("bp_cycles", nc, 16);
        chk("bp_cnt0", idx0, 16);
        chk("bp_cnt1", idx1, 16);
        @(negedge clk);
        #1;
        chk("bp_end_valid0", valid0, 0);
        chk("bp_end_valid1", valid1, 0);

        // Random ready and random FIFO writes, 1000 words.
        do_reset(0, 8'h00);
        sb_on = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (idx0 >= 1000 && idx1 >= 1000) break;
            m_ready = 1'($urandom_range(0, 1));
            if (wptr < 1000 && $urandom_range(0, 1) == 1) begin
                mem[wptr] = 8'($urandom);
                wptr++;
            end
            @(negedge clk);
        end
        chk("rand_cnt0", idx0, 1000);
        chk("rand_cnt1", idx1, 1000);

        // Reset while words sit in the skid buffer.
        do_reset(8, 8'h30);
        sb_on = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        chk("mid_buffered1", occ1, 3);
        chk("mid_valid1", valid1, 1);
        do_reset(0, 8'h00);
        sb_on = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem[k] = 8'h50 + 8'(k);
            wptr = k + 1;
            @(negedge clk);
        end
        for (int c = 0; c < 50; c++) begin
            if (idx0 >= 4 && idx1 >= 4) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_cnt0", idx0, 4);
        chk("post_rst_cnt1", idx1, 4);
        chk("post_rst_valid0", valid0, 0);
        chk("post_rst_valid1", valid1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
